// File: rtl/img_rsz_pxl_src.sv
// Raster pixel source for the image resizer: tags each accepted word with its (X,Y) and streams it out.
// Build option IMG_RSZ_PXL_SRC_SKID_EN selects a two-entry skid output stage with a registered SrcRdy.
module img_rsz_pxl_src #(
  parameter int PXL_PRIM_COLOR_W   = 8,
  parameter int PXL_PRIM_COLOR_NUM = 3,
  parameter int IMG_WIDTH_IDX_W    = 10,
  parameter int IMG_HEIGHT_IDX_W   = 10
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic [IMG_WIDTH_IDX_W-1:0]                   ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]                  ImgHeight,
  input  logic                                         FrmStart,
  input  logic [PXL_PRIM_COLOR_W*PXL_PRIM_COLOR_NUM-1:0] SrcData,
  input  logic                                         SrcVld,
  output logic                                         SrcRdy,
  output logic [PXL_PRIM_COLOR_W-1:0]                  PxlData [PXL_PRIM_COLOR_NUM],
  output logic [IMG_WIDTH_IDX_W-1:0]                   PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  PxlY,
  output logic                                         PxlVld,
  input  logic                                         PxlRdy,
  output logic                                         FrmBusy,
  output logic                                         FrmDone
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef logic [PXL_PRIM_COLOR_W-1:0] color_t;

  localparam logic [IMG_WIDTH_IDX_W-1:0]  X_ZERO     = {IMG_WIDTH_IDX_W{1'b0}};
  localparam logic [IMG_WIDTH_IDX_W-1:0]  X_ONE      = IMG_WIDTH_IDX_W'(1'b1);
  localparam logic [IMG_HEIGHT_IDX_W-1:0] Y_ZERO     = {IMG_HEIGHT_IDX_W{1'b0}};
  localparam logic [IMG_HEIGHT_IDX_W-1:0] Y_ONE      = IMG_HEIGHT_IDX_W'(1'b1);
  localparam color_t                      COLOR_ZERO = {PXL_PRIM_COLOR_W{1'b0}};

  state_t                      state_r;
  state_t                      nextState_s;
  logic [IMG_WIDTH_IDX_W-1:0]  widthLat_r;
  logic [IMG_WIDTH_IDX_W-1:0]  widthNext_s;
  logic [IMG_HEIGHT_IDX_W-1:0] heightLat_r;
  logic [IMG_HEIGHT_IDX_W-1:0] heightNext_s;
  logic [IMG_WIDTH_IDX_W-1:0]  xCnt_r;
  logic [IMG_WIDTH_IDX_W-1:0]  xNext_s;
  logic [IMG_HEIGHT_IDX_W-1:0] yCnt_r;
  logic [IMG_HEIGHT_IDX_W-1:0] yNext_s;
  logic                        frmBusy_r;
  logic                        frmDone_r;
  logic                        frmDoneNext_s;

  logic                        srcRdy_s;
  logic                        srcAcc_s;
  logic                        pxlPop_s;
  logic                        stageEmpty_s;
  logic                        lastPxl_s;

  color_t                      srcColor_s [PXL_PRIM_COLOR_NUM];
  color_t                      pxlData_r  [PXL_PRIM_COLOR_NUM];
  logic [IMG_WIDTH_IDX_W-1:0]  pxlX_r;
  logic [IMG_HEIGHT_IDX_W-1:0] pxlY_r;
  logic                        pxlVld_r;

  assign srcAcc_s  = SrcVld & srcRdy_s;
  assign pxlPop_s  = pxlVld_r & PxlRdy;
  assign lastPxl_s = (xCnt_r == widthLat_r) & (yCnt_r == heightLat_r);

  assign SrcRdy  = srcRdy_s;
  assign PxlData = pxlData_r;
  assign PxlX    = pxlX_r;
  assign PxlY    = pxlY_r;
  assign PxlVld  = pxlVld_r;
  assign FrmBusy = frmBusy_r;
  assign FrmDone = frmDone_r;

  // Split the packed raster word into per-color lanes (color 0 in the LSBs).
  always_comb begin
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
      srcColor_s[c] = SrcData[c*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W];
    end
  end

  // Frame sequencing and raster coordinate generation.
  always_comb begin
    nextState_s   = state_r;
    widthNext_s   = widthLat_r;
    heightNext_s  = heightLat_r;
    xNext_s       = xCnt_r;
    yNext_s       = yCnt_r;
    frmDoneNext_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (FrmStart) begin
          nextState_s  = STREAM;
          widthNext_s  = ImgWidth;
          heightNext_s = ImgHeight;
          xNext_s      = X_ZERO;
          yNext_s      = Y_ZERO;
        end else begin
          nextState_s = IDLE;
        end
      end
      STREAM: begin
        if (srcAcc_s) begin
          if (lastPxl_s) begin
            nextState_s = DRAIN;
          end else begin
            nextState_s = STREAM;
          end
          if (xCnt_r == widthLat_r) begin
            xNext_s = X_ZERO;
            yNext_s = yCnt_r + Y_ONE;
          end else begin
            xNext_s = xCnt_r + X_ONE;
            yNext_s = yCnt_r;
          end
        end else begin
          nextState_s = STREAM;
        end
      end
      DRAIN: begin
        // Frame completes only after the last pixel has left the output stage.
        if (stageEmpty_s) begin
          nextState_s   = IDLE;
          frmDoneNext_s = 1'b1;
        end else begin
          nextState_s = DRAIN;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, latched frame size, coordinate counters and frame status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      widthLat_r  <= X_ZERO;
      heightLat_r <= Y_ZERO;
      xCnt_r      <= X_ZERO;
      yCnt_r      <= Y_ZERO;
      frmBusy_r   <= 1'b0;
      frmDone_r   <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      widthLat_r  <= widthNext_s;
      heightLat_r <= heightNext_s;
      xCnt_r      <= xNext_s;
      yCnt_r      <= yNext_s;
      frmBusy_r   <= (nextState_s != IDLE);
      frmDone_r   <= frmDoneNext_s;
    end
  end

`ifdef IMG_RSZ_PXL_SRC_SKID_EN

  color_t                      skidData_r [PXL_PRIM_COLOR_NUM];
  logic [IMG_WIDTH_IDX_W-1:0]  skidX_r;
  logic [IMG_HEIGHT_IDX_W-1:0] skidY_r;
  logic                        skidVld_r;
  logic                        skidVldNext_s;
  logic                        srcRdy_r;

  assign srcRdy_s     = srcRdy_r;
  assign stageEmpty_s = ~pxlVld_r & ~skidVld_r;

  // Skid occupancy after the coming edge; SrcRdy is registered from it so PxlRdy never reaches SrcRdy.
  always_comb begin
    skidVldNext_s = skidVld_r;
    if (skidVld_r) begin
      skidVldNext_s = ~pxlPop_s;
    end else begin
      skidVldNext_s = pxlVld_r & srcAcc_s & ~pxlPop_s;
    end
  end

  // Two-entry output stage: output register at the head, skid register behind it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      srcRdy_r  <= 1'b0;
      skidVld_r <= 1'b0;
      skidX_r   <= X_ZERO;
      skidY_r   <= Y_ZERO;
      pxlVld_r  <= 1'b0;
      pxlX_r    <= X_ZERO;
      pxlY_r    <= Y_ZERO;
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
        skidData_r[c] <= COLOR_ZERO;
        pxlData_r[c]  <= COLOR_ZERO;
      end
    end else begin
      srcRdy_r  <= (nextState_s == STREAM) & ~skidVldNext_s;
      skidVld_r <= skidVldNext_s;
      if (skidVld_r) begin
        if (pxlPop_s) begin
          pxlData_r <= skidData_r;
          pxlX_r    <= skidX_r;
          pxlY_r    <= skidY_r;
        end
      end else if (srcAcc_s && (!pxlVld_r || pxlPop_s)) begin
        pxlVld_r  <= 1'b1;
        pxlData_r <= srcColor_s;
        pxlX_r    <= xCnt_r;
        pxlY_r    <= yCnt_r;
      end else if (srcAcc_s) begin
        skidData_r <= srcColor_s;
        skidX_r    <= xCnt_r;
        skidY_r    <= yCnt_r;
      end else if (pxlPop_s) begin
        pxlVld_r <= 1'b0;
      end
    end
  end

`else

  // Single output register: accept whenever it is empty or being drained this cycle.
  assign srcRdy_s     = (state_r == STREAM) & (~pxlVld_r | PxlRdy);
  assign stageEmpty_s = ~pxlVld_r;

  // Output register, loaded on every accepted source word.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pxlVld_r <= 1'b0;
      pxlX_r   <= X_ZERO;
      pxlY_r   <= Y_ZERO;
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
        pxlData_r[c] <= COLOR_ZERO;
      end
    end else begin
      if (srcAcc_s) begin
        pxlVld_r  <= 1'b1;
        pxlData_r <= srcColor_s;
        pxlX_r    <= xCnt_r;
        pxlY_r    <= yCnt_r;
      end else if (pxlPop_s) begin
        pxlVld_r <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_img_rsz_pxl_src.sv
// Directed, table-driven bench for img_rsz_pxl_src (default parameters); honours IMG_RSZ_PXL_SRC_SKID_EN.
module tb_img_rsz_pxl_src;

  localparam int CW = 8;
  localparam int CN = 3;
  localparam int XW = 10;
  localparam int YW = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [XW-1:0] ImgWidth = '0;
  logic [YW-1:0] ImgHeight = '0;
  logic          FrmStart = 1'b0;
  logic [CW*CN-1:0] SrcData = '0;
  logic          SrcVld = 1'b0;
  logic          SrcRdy;
  logic [CW-1:0] PxlData [CN];
  logic [XW-1:0] PxlX;
  logic [YW-1:0] PxlY;
  logic          PxlVld;
  logic          PxlRdy = 1'b0;
  logic          FrmBusy;
  logic          FrmDone;
  logic [CW*CN-1:0] pxlPacked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         w;
    int         h;
    logic [7:0] vldPat;
    logic [7:0] rdyPat;
    int         pulseAt;
    int         expTotal;
  } vec_t;

  vec_t vecs [7];

  assign pxlPacked = {PxlData[2], PxlData[1], PxlData[0]};

  img_rsz_pxl_src #(
    .PXL_PRIM_COLOR_W  (CW),
    .PXL_PRIM_COLOR_NUM(CN),
    .IMG_WIDTH_IDX_W   (XW),
    .IMG_HEIGHT_IDX_W  (YW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ImgWidth (ImgWidth),
    .ImgHeight(ImgHeight),
    .FrmStart (FrmStart),
    .SrcData  (SrcData),
    .SrcVld   (SrcVld),
    .SrcRdy   (SrcRdy),
    .PxlData  (PxlData),
    .PxlX     (PxlX),
    .PxlY     (PxlY),
    .PxlVld   (PxlVld),
    .PxlRdy   (PxlRdy),
    .FrmBusy  (FrmBusy),
    .FrmDone  (FrmDone)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] wordOf(input int k);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    a = 8'(k * 37 + 5);
    b = 8'(k + 64);
    c = 8'(k) ^ 8'hA5;
    return {c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Runs one frame from IDLE; stopAfter>0 returns early once that many pixels have left.
  task automatic runFrame(input vec_t v, input int stopAfter);
    int srcIdx = 0;
    int outIdx = 0;
    int cyc = 0;
    int firstSrc = -1;
    int firstTake = -1;
    int lastTake = -1;
    bit done = 1'b0;
    bit stallPrev = 1'b0;
    bit srcTake;
    bit pxlTake;
    logic [43:0] held = '0;
    logic [43:0] expPix;
    ImgWidth  = XW'(v.w);
    ImgHeight = YW'(v.h);
    FrmStart  = 1'b1;
    @(posedge Clk); #1;
    FrmStart  = 1'b0;
    ImgWidth  = XW'(v.w + 2);
    ImgHeight = YW'(v.h + 1);
    while (!done && cyc < 2000 && !(stopAfter > 0 && outIdx >= stopAfter)) begin
      FrmStart = (cyc == v.pulseAt);
      SrcVld   = v.vldPat[cyc % 8] && (srcIdx < v.expTotal);
      SrcData  = wordOf(srcIdx);
      PxlRdy   = v.rdyPat[cyc % 8];
      @(negedge Clk);
      srcTake = SrcVld && SrcRdy;
      pxlTake = PxlVld && PxlRdy;
      if (stallPrev) chk("stall_hold", {PxlVld, PxlX, PxlY, pxlPacked}, {1'b1, held});
      stallPrev = PxlVld && !PxlRdy;
      held = {PxlX, PxlY, pxlPacked};
      if (pxlTake) begin
        expPix = {XW'(outIdx % (v.w + 1)), YW'(outIdx / (v.w + 1)), wordOf(outIdx)};
        chk("pixel", {PxlX, PxlY, pxlPacked}, expPix);
        if (firstTake < 0) firstTake = cyc;
        lastTake = cyc;
        outIdx++;
      end
      if (srcTake && firstSrc < 0) firstSrc = cyc;
      if (FrmDone) begin
        done = 1'b1;
        chk("pixel_count", outIdx, v.expTotal);
        chk("word_count", srcIdx, v.expTotal);
        chk("done_timing", cyc, lastTake + 2);
      end else begin
        chk("busy", FrmBusy, 1'b1);
        if (srcIdx >= v.expTotal) begin
          chk("drain_rdy", SrcRdy, 1'b0);
        end else begin
`ifdef IMG_RSZ_PXL_SRC_SKID_EN
          if (!PxlVld) chk("stream_rdy", SrcRdy, 1'b1);
`else
          chk("stream_rdy", SrcRdy, !PxlVld || PxlRdy);
`endif
        end
      end
      @(posedge Clk); #1;
      if (srcTake) srcIdx++;
      cyc++;
    end
    FrmStart = 1'b0;
    if (stopAfter == 0) begin
      chk("frame_done_seen", done, 1'b1);
      if (v.vldPat == 8'hFF && v.rdyPat == 8'hFF) begin
        chk("first_src", firstSrc, 0);
        chk("latency", firstTake, firstSrc + 1);
        chk("no_bubble", lastTake - firstTake, v.expTotal - 1);
      end
      SrcVld = 1'b1;
      PxlRdy = 1'b1;
      @(negedge Clk);
      chk("after_done_idle", {FrmDone, FrmBusy, PxlVld, SrcRdy}, 4'b0000);
      @(posedge Clk); #1;
      SrcVld = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    bit   found;
    logic r0;
    logic r1;

    vecs[0] = '{w: 3, h: 1, vldPat: 8'hFF, rdyPat: 8'hFF, pulseAt: -1, expTotal: 8};
    vecs[1] = '{w: 2, h: 2, vldPat: 8'hFF, rdyPat: 8'h55, pulseAt: -1, expTotal: 9};
    vecs[2] = '{w: 7, h: 5, vldPat: 8'hB7, rdyPat: 8'hD9, pulseAt: -1, expTotal: 48};
    vecs[3] = '{w: 4, h: 2, vldPat: 8'hFF, rdyPat: 8'hFF, pulseAt: 3, expTotal: 15};
    vecs[4] = '{w: 0, h: 0, vldPat: 8'hFF, rdyPat: 8'hFF, pulseAt: -1, expTotal: 1};
    vecs[5] = '{w: 7, h: 5, vldPat: 8'h6D, rdyPat: 8'h37, pulseAt: -1, expTotal: 48};
    vecs[6] = '{w: 5, h: 1, vldPat: 8'hFF, rdyPat: 8'h0F, pulseAt: -1, expTotal: 12};

    // Reset state, then idle behaviour without a frame start.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_state", {PxlVld, SrcRdy, FrmBusy, FrmDone, PxlX, PxlY, pxlPacked}, 64'd0);
    @(posedge Clk); #1;
    Reset  = 1'b1;
    SrcVld = 1'b1;
    @(negedge Clk);
    chk("idle_no_start", {PxlVld, SrcRdy, FrmBusy, FrmDone}, 4'b0000);
    @(posedge Clk); #1;
    SrcVld = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runFrame(vecs[i], 0);
    end

    // Single-pixel frame with a known payload, held under back-pressure.
    ImgWidth  = 10'd0;
    ImgHeight = 10'd0;
    FrmStart  = 1'b1;
    PxlRdy    = 1'b0;
    SrcVld    = 1'b1;
    SrcData   = 24'h123456;
    @(posedge Clk); #1;
    FrmStart = 1'b0;
    @(posedge Clk); #1;
    SrcVld = 1'b0;
    @(negedge Clk);
    chk("one_pxl_pos", {PxlVld, PxlX, PxlY}, {1'b1, 10'd0, 10'd0});
    chk("one_pxl_c0", PxlData[0], 8'h56);
    chk("one_pxl_c1", PxlData[1], 8'h34);
    chk("one_pxl_c2", PxlData[2], 8'h12);
    chk("one_drain", {SrcRdy, FrmBusy}, 2'b01);
    @(posedge Clk); #1;
    PxlRdy = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge Clk);
      if (FrmDone) found = 1'b1;
    end
    chk("one_done", found, 1'b1);
    @(negedge Clk);
    chk("one_idle", {FrmDone, FrmBusy, PxlVld}, 3'b000);
    @(posedge Clk); #1;

    // SrcRdy response to PxlRdy within a cycle, then asynchronous reset mid-frame.
    ImgWidth  = 10'd7;
    ImgHeight = 10'd5;
    FrmStart  = 1'b1;
    PxlRdy    = 1'b0;
    @(posedge Clk); #1;
    FrmStart = 1'b0;
    SrcVld   = 1'b1;
    SrcData  = wordOf(0);
    @(posedge Clk); #1;
    SrcVld = 1'b0;
    r0 = SrcRdy;
    PxlRdy = 1'b1;
    #1;
    r1 = SrcRdy;
`ifdef IMG_RSZ_PXL_SRC_SKID_EN
    chk("rdy_path", {PxlVld, r0, r1}, 3'b111);
`else
    chk("rdy_path", {PxlVld, r0, r1}, 3'b101);
`endif
    Reset = 1'b0;
    #1;
    chk("reset_async", {PxlVld, SrcRdy, FrmBusy, FrmDone, PxlX, PxlY, pxlPacked}, 64'd0);
    @(posedge Clk); #1;
    Reset  = 1'b1;
    PxlRdy = 1'b0;

    // Reset after 5 of 16 pixels, then a fresh 2-pixel frame.
    v = '{w: 3, h: 3, vldPat: 8'hFF, rdyPat: 8'hFF, pulseAt: -1, expTotal: 16};
    runFrame(v, 5);
    Reset = 1'b0;
    #1;
    chk("reset_mid", {PxlVld, SrcRdy, FrmBusy, FrmDone, PxlX, PxlY, pxlPacked}, 64'd0);
    @(posedge Clk); #1;
    Reset  = 1'b1;
    SrcVld = 1'b1;
    PxlRdy = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_wait_start", {PxlVld, SrcRdy, FrmBusy, FrmDone}, 4'b0000);
    @(posedge Clk); #1;
    SrcVld = 1'b0;
    v = '{w: 1, h: 0, vldPat: 8'hFF, rdyPat: 8'hFF, pulseAt: -1, expTotal: 2};
    runFrame(v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_rsz_pxl_src.md
IMG_RSZ_PXL_SRC -- requirements
Module: img_rsz_pxl_src

Interface
REQ-001 SHALL take parameter PXL_PRIM_COLOR_W, default 8, bits per primary color.
REQ-002 SHALL take parameter PXL_PRIM_COLOR_NUM, default 3, primary colors per pixel.
REQ-003 SHALL take parameter IMG_WIDTH_IDX_W, default 10, column index width.
REQ-004 SHALL take parameter IMG_HEIGHT_IDX_W, default 10, row index width.
REQ-005 SHALL have Clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ImgWidth  in  IMG_WIDTH_IDX_W  last column index of the frame (columns minus 1).
REQ-008 SHALL have ImgHeight  in  IMG_HEIGHT_IDX_W  last row index of the frame (rows minus 1).
REQ-009 SHALL have FrmStart  in  1  one-cycle frame start request.
REQ-010 SHALL have SrcData  in  PXL_PRIM_COLOR_W*PXL_PRIM_COLOR_NUM  packed raster pixel; color c at bits [c*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W].
REQ-011 SHALL have SrcVld  in  1  and SrcRdy  out  1  raster input handshake.
REQ-012 SHALL have PxlData  out  PXL_PRIM_COLOR_W x PXL_PRIM_COLOR_NUM (unpacked)  pixel colors toward the resizer.
REQ-013 SHALL have PxlX  out  IMG_WIDTH_IDX_W  and PxlY  out  IMG_HEIGHT_IDX_W  pixel coordinates.
REQ-014 SHALL have PxlVld  out  1  and PxlRdy  in  1  resizer pixel handshake.
REQ-015 SHALL have FrmBusy  out  1  (frame in progress) and FrmDone  out  1  (one-cycle pulse at frame end).

Function
REQ-016 SHALL implement states IDLE, STREAM, DRAIN; reset state IDLE.
REQ-017 IDLE: FrmStart=1 SHALL latch ImgWidth/ImgHeight, clear X/Y counters, enter STREAM next cycle; FrmStart outside IDLE SHALL be ignored.
REQ-018 A transfer on either interface SHALL occur only on a cycle with Vld=1 and Rdy=1.
REQ-019 SrcRdy SHALL be 0 in IDLE and DRAIN; in STREAM it SHALL be 1 whenever the output stage can accept a word.
REQ-020 Each accepted source word SHALL be tagged with the current (X,Y), then X SHALL increment; at X=latched width X SHALL wrap to 0 and Y SHALL increment.
REQ-021 Acceptance of the word tagged (latched width, latched height) SHALL move STREAM->DRAIN the same edge.
REQ-022 DRAIN: once the output stage is empty, FrmDone SHALL pulse for exactly one cycle and the state SHALL return to IDLE.
REQ-023 FrmBusy SHALL be 1 in STREAM and DRAIN, 0 in IDLE.
REQ-024 Latency SHALL be one cycle: a word accepted at edge N SHALL appear on PxlVld/PxlData/PxlX/PxlY after edge N.
REQ-025 While PxlVld=1 and PxlRdy=0, PxlData/PxlX/PxlY SHALL be held stable; PxlVld SHALL not drop without a transfer.
REQ-026 Accept-in and transfer-out on the same edge SHALL sustain one pixel per cycle with no bubble.
REQ-027 ImgWidth=0, ImgHeight=0 SHALL produce a one-pixel frame at (0,0).
REQ-028 Pixel order SHALL be strict raster; no pixel dropped or duplicated; total pixels = (W+1)*(H+1).

Reset
REQ-029 Reset low SHALL immediately force: state IDLE, PxlVld=0, SrcRdy=0, FrmBusy=0, FrmDone=0, PxlX=0, PxlY=0, PxlData all 0, counters and latched sizes 0.
REQ-030 Reset mid-frame SHALL discard all buffered pixels; after release the block SHALL wait for a new FrmStart.

Configuration
REQ-031 Macro IMG_RSZ_PXL_SRC_SKID_EN SHALL select the output stage.
REQ-032 Defined: two-entry skid buffer; SrcRdy SHALL be a registered signal equal to "buffer not full" in STREAM, with no combinational path from PxlRdy to SrcRdy.
REQ-033 Undefined: single output register; SrcRdy SHALL equal (!PxlVld || PxlRdy) in STREAM (combinational path permitted).
REQ-034 Both builds SHALL meet REQ-024..REQ-028 identically at the pixel stream.

Verification
REQ-035 W=3,H=1, SrcVld=1 constant, PxlRdy=1 -> 8 pixels (0,0)..(3,1) on consecutive cycles, FrmDone one cycle after last transfer.
REQ-036 W=H=0, one source word 0x123456 -> single pixel (0,0), PxlData[0]=0x56,[1]=0x34,[2]=0x12, FrmDone pulse, IDLE.
REQ-037 W=2,H=2, PxlRdy toggling 1/0 each cycle -> 9 pixels in raster order, payload stable during every stall.
REQ-038 Reset asserted after 5 of 16 pixels (W=3,H=3) -> PxlVld=0 at once; new FrmStart W=1,H=0 -> 2 pixels (0,0),(1,0) only.
REQ-039 FrmStart pulsed mid-STREAM with different sizes -> ignored, coordinates follow original sizes.
REQ-040 Both macro settings, random SrcVld/PxlRdy, W=7,H=5 -> 48 pixels match reference model; SKID_EN build shows no PxlRdy->SrcRdy path.
